// File: rtl/urv_writeback_pkg.sv
// Shared definitions for the uRV writeback stage: FSM state encodings
// and the load funct3 codes understood by the load aligner.
package urv_writeback_pkg;

  typedef enum logic [1:0] {
    WB_IDLE   = 2'd0,
    WB_COMMIT = 2'd1,
    WB_LOAD   = 2'd2
  } wb_state_t;

  localparam logic [2:0] FUN_LB  = 3'b000;
  localparam logic [2:0] FUN_LH  = 3'b001;
  localparam logic [2:0] FUN_LW  = 3'b010;
  localparam logic [2:0] FUN_LBU = 3'b100;
  localparam logic [2:0] FUN_LHU = 3'b101;

endpackage

// File: rtl/urv_load_align.sv
// Combinational load aligner: picks the byte/halfword addressed by the
// low address bits, sign- or zero-extends it, and flags accesses that are
// not naturally aligned. Unknown funct3 codes behave as LW.
module urv_load_align
  import urv_writeback_pkg::*;
(
  input  logic [2:0]  fun,
  input  logic [1:0]  addr,
  input  logic [31:0] data,
  output logic [31:0] result,
  output logic        misaligned
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Lane selection, extension and alignment check.
  always_comb begin
    byte_sel   = data[7:0];
    half_sel   = addr[1] ? data[31:16] : data[15:0];
    result     = data;
    misaligned = 1'b0;

    case (addr)
      2'd0:    byte_sel = data[7:0];
      2'd1:    byte_sel = data[15:8];
      2'd2:    byte_sel = data[23:16];
      default: byte_sel = data[31:24];
    endcase

    case (fun)
      FUN_LB:  result = {{24{byte_sel[7]}}, byte_sel};
      FUN_LBU: result = {24'h000000, byte_sel};
      FUN_LH: begin
        result     = {{16{half_sel[15]}}, half_sel};
        misaligned = addr[0];
      end
      FUN_LHU: begin
        result     = {16'h0000, half_sel};
        misaligned = addr[0];
      end
      default: begin
        result     = data;
        misaligned = (addr != 2'b00);
      end
    endcase
  end

endmodule

// File: rtl/urv_writeback.sv
// uRV writeback stage. Holds one completed execute op, waits for load data
// when needed, drives the register-file write port and the execute bypass,
// and counts retired instructions.
// Optional build macro URV_WB_MISALIGN_TRAP_EN: misaligned LH/LHU/LW loads
// pulse w_misaligned_o, are not written and are not retired.
module urv_writeback
  import urv_writeback_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        x_valid_i,
  input  logic [4:0]  x_rd_i,
  input  logic [31:0] x_rd_value_i,
  input  logic        x_rd_write_i,
  input  logic        x_load_i,
  input  logic [2:0]  x_fun_i,
  input  logic [1:0]  x_dm_addr_i,
  input  logic [31:0] dm_data_l_i,
  input  logic        dm_load_done_i,
  output logic        w_stall_o,
  output logic [4:0]  w_rd_o,
  output logic [31:0] w_rd_value_o,
  output logic        w_rd_store_o,
  output logic        w_bypass_rd_write_o,
  output logic [31:0] w_bypass_rd_value_o,
  output logic [63:0] w_instret_o,
  output logic        w_misaligned_o
);

  wb_state_t   state;
  logic [4:0]  rd_p0;
  logic [31:0] val_p0;
  logic        wr_p0;
  logic [2:0]  fun_p0;
  logic [1:0]  addr_p0;

  logic [31:0] load_value;
  logic        load_mis;
  logic        load_done;
  logic        trap;
  logic        load_ok;
  logic        commit;
  logic        retire;

  urv_load_align u_align (
    .fun        (fun_p0),
    .addr       (addr_p0),
    .data       (dm_data_l_i),
    .result     (load_value),
    .misaligned (load_mis)
  );

  // Completion terms are masked during reset so a pending load cannot write.
  assign load_done = (state == WB_LOAD) & dm_load_done_i & ~rst_i;
  assign commit    = (state == WB_COMMIT) & ~rst_i;

`ifdef URV_WB_MISALIGN_TRAP_EN
  assign trap = load_done & load_mis;
`else
  logic unused_load_mis;
  assign unused_load_mis = load_mis;
  assign trap            = 1'b0;
`endif

  assign load_ok = load_done & ~trap;
  assign retire  = commit | load_ok;

  assign w_stall_o           = (state == WB_LOAD) & ~dm_load_done_i & ~rst_i;
  assign w_rd_o              = rd_p0;
  assign w_rd_value_o        = (state == WB_LOAD) ? load_value : val_p0;
  assign w_rd_store_o        = retire & wr_p0 & (rd_p0 != 5'd0);
  assign w_bypass_rd_write_o = w_rd_store_o;
  assign w_bypass_rd_value_o = w_rd_value_o;
  assign w_misaligned_o      = trap;

  // FSM and held control/result fields; capture whenever the stage is not stalled.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state  <= WB_IDLE;
      rd_p0  <= 5'd0;
      val_p0 <= 32'd0;
      wr_p0  <= 1'b0;
    end else if (!w_stall_o) begin
      rd_p0  <= x_rd_i;
      val_p0 <= x_rd_value_i;
      wr_p0  <= x_rd_write_i;
      if (!x_valid_i)
        state <= WB_IDLE;
      else if (x_load_i)
        state <= WB_LOAD;
      else
        state <= WB_COMMIT;
    end
  end

  // Load decode fields only matter in WB_LOAD, so they carry no reset.
  always_ff @(posedge clk_i) begin
    if (!w_stall_o) begin
      fun_p0  <= x_fun_i;
      addr_p0 <= x_dm_addr_i;
    end
  end

  // Retired-instruction counter, wraps modulo 2^64.
  always_ff @(posedge clk_i) begin
    if (rst_i)
      w_instret_o <= 64'd0;
    else if (retire)
      w_instret_o <= w_instret_o + 64'd1;
  end

endmodule

// File: tb/tb_urv_writeback.sv
// Testbench for urv_writeback: directed stimulus, expected register-file
// writes queued in a scoreboard and popped by a negedge monitor.
module tb_urv_writeback;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        x_valid_i;
  logic [4:0]  x_rd_i;
  logic [31:0] x_rd_value_i;
  logic        x_rd_write_i;
  logic        x_load_i;
  logic [2:0]  x_fun_i;
  logic [1:0]  x_dm_addr_i;
  logic [31:0] dm_data_l_i;
  logic        dm_load_done_i;
  logic        w_stall_o;
  logic [4:0]  w_rd_o;
  logic [31:0] w_rd_value_o;
  logic        w_rd_store_o;
  logic        w_bypass_rd_write_o;
  logic [31:0] w_bypass_rd_value_o;
  logic [63:0] w_instret_o;
  logic        w_misaligned_o;

  int n_checks = 0;
  int n_fail   = 0;
  logic [36:0] exp_q[$];   // {rd, value}
  logic [63:0] exp_instret;

  urv_writeback dut (
    .clk_i               (clk_i),
    .rst_i               (rst_i),
    .x_valid_i           (x_valid_i),
    .x_rd_i              (x_rd_i),
    .x_rd_value_i        (x_rd_value_i),
    .x_rd_write_i        (x_rd_write_i),
    .x_load_i            (x_load_i),
    .x_fun_i             (x_fun_i),
    .x_dm_addr_i         (x_dm_addr_i),
    .dm_data_l_i         (dm_data_l_i),
    .dm_load_done_i      (dm_load_done_i),
    .w_stall_o           (w_stall_o),
    .w_rd_o              (w_rd_o),
    .w_rd_value_o        (w_rd_value_o),
    .w_rd_store_o        (w_rd_store_o),
    .w_bypass_rd_write_o (w_bypass_rd_write_o),
    .w_bypass_rd_value_o (w_bypass_rd_value_o),
    .w_instret_o         (w_instret_o),
    .w_misaligned_o      (w_misaligned_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every register-file write must match the oldest queued expectation.
  always @(negedge clk_i) begin
    if (w_rd_store_o === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_write_rd", {59'd0, w_rd_o}, 64'h0);
        chk("unexpected_write_en", {63'd0, w_rd_store_o}, 64'h0);
      end else begin
        logic [36:0] e;
        e = exp_q.pop_front();
        chk("wr_rd", {59'd0, w_rd_o}, {59'd0, e[36:32]});
        chk("wr_value", {32'd0, w_rd_value_o}, {32'd0, e[31:0]});
        chk("byp_write", {63'd0, w_bypass_rd_write_o}, 64'd1);
        chk("byp_value", {32'd0, w_bypass_rd_value_o}, {32'd0, e[31:0]});
      end
    end
  end

  task automatic drive_op(input logic v, input logic [4:0] rd, input logic [31:0] val,
                          input logic wr, input logic ld, input logic [2:0] fun,
                          input logic [1:0] addr);
    @(posedge clk_i); #1;
    x_valid_i    = v;
    x_rd_i       = rd;
    x_rd_value_i = val;
    x_rd_write_i = wr;
    x_load_i     = ld;
    x_fun_i      = fun;
    x_dm_addr_i  = addr;
  endtask

  // Issue a load, hold off completion for 'waits' cycles, then present data.
  task automatic do_load(input logic [4:0] rd, input logic [2:0] fun, input logic [1:0] addr,
                         input logic [31:0] data, input int waits, input logic [31:0] expv);
    drive_op(1'b1, rd, 32'hDEAD0000, 1'b1, 1'b1, fun, addr);
    exp_q.push_back({rd, expv});
    for (int i = 0; i < waits; i++) begin
      @(posedge clk_i); #1;
      x_valid_i = 1'b0;
      @(negedge clk_i);
      chk("stall_wait", {63'd0, w_stall_o}, 64'd1);
    end
    @(posedge clk_i); #1;
    x_valid_i      = 1'b0;
    dm_data_l_i    = data;
    dm_load_done_i = 1'b1;
    @(negedge clk_i);
    chk("stall_done", {63'd0, w_stall_o}, 64'd0);
    @(posedge clk_i); #1;
    dm_load_done_i = 1'b0;
    exp_instret++;
    @(negedge clk_i);
    chk("instret_load", w_instret_o, exp_instret);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_i = 1'b1; x_valid_i = 1'b0; x_rd_i = '0; x_rd_value_i = '0; x_rd_write_i = 1'b0;
    x_load_i = 1'b0; x_fun_i = '0; x_dm_addr_i = '0; dm_data_l_i = '0; dm_load_done_i = 1'b0;
    exp_instret = 64'd0;
    repeat (2) @(posedge clk_i);
    #1 rst_i = 1'b0;
    @(negedge clk_i);
    chk("rst_stall", {63'd0, w_stall_o}, 64'd0);
    chk("rst_store", {63'd0, w_rd_store_o}, 64'd0);
    chk("rst_instret", w_instret_o, 64'd0);
    chk("rst_rd", {59'd0, w_rd_o}, 64'd0);
    chk("rst_value", {32'd0, w_rd_value_o}, 64'd0);
    chk("rst_mis", {63'd0, w_misaligned_o}, 64'd0);

    // ALU burst: three back-to-back commits.
    drive_op(1'b1, 5'd1, 32'h11, 1'b1, 1'b0, 3'b000, 2'd0);
    exp_q.push_back({5'd1, 32'h11});
    drive_op(1'b1, 5'd2, 32'h22, 1'b1, 1'b0, 3'b000, 2'd0);
    exp_q.push_back({5'd2, 32'h22});
    @(negedge clk_i); chk("burst_store1", {63'd0, w_rd_store_o}, 64'd1);
    drive_op(1'b1, 5'd3, 32'h33, 1'b1, 1'b0, 3'b000, 2'd0);
    exp_q.push_back({5'd3, 32'h33});
    @(negedge clk_i); chk("burst_store2", {63'd0, w_rd_store_o}, 64'd1);
    drive_op(1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 3'b000, 2'd0);
    @(negedge clk_i); chk("burst_store3", {63'd0, w_rd_store_o}, 64'd1);
    @(posedge clk_i);
    @(negedge clk_i);
    chk("burst_idle", {63'd0, w_rd_store_o}, 64'd0);
    exp_instret = 64'd3;
    chk("burst_instret", w_instret_o, exp_instret);

    // Loads: alignment and extension cases.
    do_load(5'd5, 3'b000, 2'd3, 32'h80123456, 4, 32'hFFFFFF80);  // LB, 4-cycle wait
    do_load(5'd6, 3'b101, 2'd2, 32'hBEEF1234, 0, 32'h0000BEEF);  // LHU
    do_load(5'd7, 3'b010, 2'd0, 32'hCAFEF00D, 0, 32'hCAFEF00D);  // LW, no stall
    do_load(5'd12, 3'b001, 2'd0, 32'h00008001, 1, 32'hFFFF8001); // LH
    do_load(5'd13, 3'b100, 2'd1, 32'h0000F000, 0, 32'h000000F0); // LBU
    do_load(5'd14, 3'b011, 2'd0, 32'h76543210, 0, 32'h76543210); // undefined funct3 as LW

    // rd=0 commit, then a load completing while the next op waits.
    drive_op(1'b1, 5'd0, 32'h99, 1'b1, 1'b0, 3'b000, 2'd0);
    drive_op(1'b1, 5'd8, 32'h0, 1'b1, 1'b1, 3'b010, 2'd0);
    exp_q.push_back({5'd8, 32'h12345678});
    @(negedge clk_i); chk("rd0_no_store", {63'd0, w_rd_store_o}, 64'd0);
    drive_op(1'b1, 5'd9, 32'h55, 1'b1, 1'b0, 3'b000, 2'd0);
    exp_q.push_back({5'd9, 32'h55});
    exp_instret++;
    @(negedge clk_i);
    chk("pend_stall", {63'd0, w_stall_o}, 64'd1);
    chk("rd0_instret", w_instret_o, exp_instret);
    @(posedge clk_i); #1;
    dm_data_l_i = 32'h12345678; dm_load_done_i = 1'b1;
    @(negedge clk_i); chk("pend_release", {63'd0, w_stall_o}, 64'd0);
    drive_op(1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 3'b000, 2'd0);
    dm_load_done_i = 1'b0;
    exp_instret++;
    @(negedge clk_i);
    chk("next_captured", {63'd0, w_rd_store_o}, 64'd1);
    @(posedge clk_i);
    exp_instret++;
    @(negedge clk_i); chk("pend_instret", w_instret_o, exp_instret);

    // Reset while a load is pending, then a late done.
    drive_op(1'b1, 5'd10, 32'h0, 1'b1, 1'b1, 3'b010, 2'd0);
    @(posedge clk_i); #1;
    rst_i = 1'b1; x_valid_i = 1'b0;
    @(posedge clk_i); #1;
    rst_i = 1'b0; dm_data_l_i = 32'hA5A5A5A5; dm_load_done_i = 1'b1;
    @(negedge clk_i);
    chk("rstld_store", {63'd0, w_rd_store_o}, 64'd0);
    chk("rstld_stall", {63'd0, w_stall_o}, 64'd0);
    chk("rstld_instret", w_instret_o, 64'd0);
    @(posedge clk_i); #1;
    dm_load_done_i = 1'b0;
    @(negedge clk_i);
    chk("rstld_store2", {63'd0, w_rd_store_o}, 64'd0);
    chk("rstld_instret2", w_instret_o, 64'd0);
    exp_instret = 64'd0;

    // Misaligned word load.
`ifdef URV_WB_MISALIGN_TRAP_EN
    drive_op(1'b1, 5'd11, 32'h0, 1'b1, 1'b1, 3'b010, 2'd1);
    @(posedge clk_i); #1;
    x_valid_i = 1'b0; dm_data_l_i = 32'h11223344; dm_load_done_i = 1'b1;
    @(negedge clk_i);
    chk("mis_pulse", {63'd0, w_misaligned_o}, 64'd1);
    chk("mis_no_store", {63'd0, w_rd_store_o}, 64'd0);
    @(posedge clk_i); #1;
    dm_load_done_i = 1'b0;
    @(negedge clk_i);
    chk("mis_pulse_end", {63'd0, w_misaligned_o}, 64'd0);
    chk("mis_instret", w_instret_o, exp_instret);
`else
    do_load(5'd11, 3'b010, 2'd1, 32'h11223344, 0, 32'h11223344);
    chk("mis_tied", {63'd0, w_misaligned_o}, 64'd0);
    do_load(5'd15, 3'b001, 2'd3, 32'h9ABC0000, 0, 32'hFFFF9ABC);
`endif

    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
